// File: rtl/stream_pkg.sv
// Flag bit positions and widths shared by all valid/busy stream stages.
package stream_pkg;
   localparam int MF_A = 3;
   localparam int MF_F = 2;
   localparam int MF_L = 1;
   localparam int MF_V = 0;
   localparam int SF_B = 0;
   localparam int SF_X = 1;
   localparam int MFW  = 4;
   localparam int SFW  = 2;
endpackage

// File: rtl/stream_buf2.sv
// Two-entry FIFO between a stream producer and a valid/busy consumer; push lands
// on the output the next cycle, and full gates the producer so the head never changes under a stall.
module stream_buf2 #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] din,
   input  logic          push,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          vld,
   output logic          full
);
   logic [DW-1:0] head;
   logic [DW-1:0] tail;
   logic [1:0]    count;
   logic          do_push;
   logic          do_pop;

   assign vld     = (count != 2'd0);
   assign full    = (count == 2'd2);
   assign dout    = head;
   assign do_push = push & ~full;
   assign do_pop  = pop & vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= 2'd0;
      end else begin
         unique case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) head <= din;
               else               tail <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            // Only reachable at count 1: the new beat replaces the departing head.
            2'b11: head <= din;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/csc_pack.sv
// Joins three signed channels into one rounded, saturated pixel stream; output valid one cycle
// after the join fires, and upstream is held busy while the 2-entry output buffer is full.
module csc_pack
   import stream_pkg::*;
#(
   parameter int W  = 16,
   parameter int SH = 2,
   parameter int OW = 8,
   parameter int CW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [W-1:0]    y0,
   input  logic [W-1:0]    y1,
   input  logic [W-1:0]    y2,
   input  logic [MFW-1:0]  y0_mflags,
   input  logic [MFW-1:0]  y1_mflags,
   input  logic [MFW-1:0]  y2_mflags,
   output logic [SFW-1:0]  y0_sflags,
   output logic [SFW-1:0]  y1_sflags,
   output logic [SFW-1:0]  y2_sflags,
   output logic [3*OW-1:0] z_d0,
   output logic [MFW-1:0]  z_mflags,
   input  logic [SFW-1:0]  z_sflags,
   output logic            err,
   output logic [CW-1:0]   sat_cnt,
   input  logic            clr
);
   localparam int DW = 3*OW + 3;
   localparam logic signed [W:0] HALF = {{W{1'b0}}, 1'b1} << (SH-1);
   localparam logic signed [W:0] MAXV = {{(W+1-OW){1'b0}}, {OW{1'b1}}};

   // Returns {sat, value}: round half up, then clamp to the unsigned output range.
   function automatic logic [OW:0] rnd_sat(input logic [W-1:0] y);
      logic signed [W:0] t;
      t = ($signed({y[W-1], y}) + HALF) >>> SH;
      if (t[W])           rnd_sat = {1'b1, {OW{1'b0}}};
      else if (t > MAXV)  rnd_sat = {1'b1, {OW{1'b1}}};
      else                rnd_sat = {1'b0, t[OW-1:0]};
   endfunction

   logic [2:0][W-1:0]  ych;
   logic [2:0][OW-1:0] c;
   logic [2:0]         sat;
   logic [1:0]         nsat;
   logic [CW:0]        sum;
   logic               fire;
   logic               full;
   logic               vld;
   logic               pop;
   logic               mismatch;
   logic [DW-1:0]      din;
   logic [DW-1:0]      dout;
   logic               unused_ok;

   assign ych = {y2, y1, y0};

   always_comb begin
      c   = '0;
      sat = '0;
      for (int i = 0; i < 3; i++) {sat[i], c[i]} = rnd_sat(ych[i]);
   end

   assign fire = y0_mflags[MF_V] & y1_mflags[MF_V] & y2_mflags[MF_V] & ~full;
   assign y0_sflags = {1'b0, ~fire};
   assign y1_sflags = {1'b0, ~fire};
   assign y2_sflags = {1'b0, ~fire};

   assign mismatch = (y0_mflags[MF_F] != y1_mflags[MF_F]) | (y0_mflags[MF_F] != y2_mflags[MF_F])
                   | (y0_mflags[MF_L] != y1_mflags[MF_L]) | (y0_mflags[MF_L] != y2_mflags[MF_L]);

   assign nsat = {1'b0, sat[0]} + {1'b0, sat[1]} + {1'b0, sat[2]};
   assign sum  = {1'b0, sat_cnt} + {{(CW-1){1'b0}}, nsat};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err     <= 1'b0;
         sat_cnt <= '0;
      end else begin
         if (clr)                  err <= 1'b0;
         else if (fire & mismatch) err <= 1'b1;

         if (clr)       sat_cnt <= fire ? {{(CW-2){1'b0}}, nsat} : '0;
         else if (fire) sat_cnt <= sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
      end
   end

   assign din = {y0_mflags[MF_A], y0_mflags[MF_F], y0_mflags[MF_L], c[2], c[1], c[0]};
   assign pop = vld & ~z_sflags[SF_B];

   stream_buf2 #(.DW(DW)) u_buf (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (din),
      .push (fire),
      .pop  (pop),
      .dout (dout),
      .vld  (vld),
      .full (full)
   );

   assign z_d0     = dout[3*OW-1:0];
   assign z_mflags = {dout[DW-1:DW-3], vld};

   assign unused_ok = ^{z_sflags[SF_X], y1_mflags[MF_A], y2_mflags[MF_A]};
endmodule
